q_learning_agent_param: RTL and testbench

Parametrised, self-contained tabular Q-learning agent. It holds the Q-table on-chip and selects actions epsilon-greedily using an internal LFSR. It applies the update Q(s,a) += alpha*(r + gamma*maxQ(s',·) - Q(s,a)) for each step the environment returns. This is the successor to the fixed-width agent top: configurable state/action counts and widths, plus a step handshake, terminal/episode handling, exploration, table clear and saturating arithmetic.

---
 rtl/q_learning_agent_param.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_q_learning_agent_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_learning_agent_param.sv
// -----------------------------------------------------------------------------
// q_learning_agent_param
//
// Tabular Q-learning agent with an on-chip Q-table (asynchronous read,
// synchronous write). Actions are chosen epsilon-greedily using an internal
// 16-bit Galois LFSR. Each step returned by the environment is folded into the
// table with the rule Q(s,a) += alpha*(r + gamma*maxQ(s',.) - Q(s,a)), where
// alpha and gamma are in 1/16 units and the result saturates to Q_W bits.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin an episode at init_state (only taken in IDLE)
//   init_state      first state of the episode
//   step_valid      environment result valid
//   step_ready      agent accepts a result (high only in WAIT)
//   reward          signed reward for the last action
//   next_state      state reached by the last action
//   terminal        next_state ends the episode
//   gamma, alpha    discount and learning rate, value/16
//   epsilon         exploration threshold, value/256
//   explore_en      enable random exploration
//   action_valid    action/cur_state are valid (high only in WAIT)
//   action          chosen action
//   cur_state       state the action applies to
//   explored        the chosen action was random
//   episode_done    one-cycle pulse after the terminal update
//   busy            table clear in progress
//   update_count    number of Q updates since reset (wraps)
// -----------------------------------------------------------------------------
module q_learning_agent_param #(
    parameter int          N_STATES  = 64,
    parameter int          N_ACTIONS = 4,
    parameter int          Q_W       = 16,
    parameter int          R_W       = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         S_W = (N_STATES  > 1) ? $clog2(N_STATES)  : 1,
    localparam int         A_W = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S_W-1:0] init_state,
    input  logic           step_valid,
    output logic           step_ready,
    input  logic [R_W-1:0] reward,
    input  logic [S_W-1:0] next_state,
    input  logic           terminal,
    input  logic [3:0]     gamma,
    input  logic [3:0]     alpha,
    input  logic [7:0]     epsilon,
    input  logic           explore_en,
    output logic           action_valid,
    output logic [A_W-1:0] action,
    output logic [S_W-1:0] cur_state,
    output logic           explored,
    output logic           episode_done,
    output logic           busy,
    output logic [31:0]    update_count
);

    localparam int N_ENT = N_STATES * N_ACTIONS;
    localparam int T_W   = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int I_W   = Q_W + 8;

    localparam logic signed [I_W-1:0] Q_MAX = {{(I_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
    localparam logic signed [I_W-1:0] Q_MIN = {{(I_W-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN_SEL,
        ST_WAIT,
        ST_SCAN_UPD,
        ST_UPDATE
    } state_t;

    state_t state, state_nx;

    // Flattened table address: state-major, action-minor.
    function automatic logic [T_W-1:0] tab_addr(input logic [S_W-1:0] s,
                                                 input logic [A_W-1:0] a);
        logic [31:0] flat;
        flat = 32'(s) * 32'(N_ACTIONS) + 32'(a);
        return flat[T_W-1:0];
    endfunction

    // Clamp a wide intermediate into the signed Q_W range.
    function automatic logic signed [Q_W-1:0] sat_q(input logic signed [I_W-1:0] v);
        logic signed [I_W-1:0] c;
        if (v > Q_MAX)      c = Q_MAX;
        else if (v < Q_MIN) c = Q_MIN;
        else                c = v;
        return c[Q_W-1:0];
    endfunction

    logic signed [Q_W-1:0] q_tab [N_ENT];

    logic [15:0]           lfsr;
    logic [15:0]           lfsr_nx;
    logic [T_W-1:0]        clr_idx;
    logic                  clr_last;
    logic [A_W-1:0]        scan_idx;
    logic                  scan_last;
    logic                  scanning;
    logic                  accept;

    logic signed [Q_W-1:0] best_q;
    logic [A_W-1:0]        best_a;
    logic signed [Q_W-1:0] cand_q;
    logic [A_W-1:0]        cand_a;
    logic [S_W-1:0]        scan_tgt;
    logic signed [Q_W-1:0] scan_q;

    logic signed [R_W-1:0] rew_l;
    logic [S_W-1:0]        nxt_l;
    logic                  term_l;
    logic signed [Q_W-1:0] maxq_l;

    logic                  explore_hit;
    logic [A_W-1:0]        rnd_a;
    logic                  rnd_ok;
    logic [A_W-1:0]        sel_action;
    logic                  sel_explore;

    logic [T_W-1:0]        upd_addr;
    logic signed [Q_W-1:0] upd_q;
    logic signed [I_W-1:0] gamma_s;
    logic signed [I_W-1:0] alpha_s;
    logic signed [I_W-1:0] maxq_s;
    logic signed [I_W-1:0] rew_s;
    logic signed [I_W-1:0] q_s;
    logic signed [I_W-1:0] prod_g;
    logic signed [I_W-1:0] tgt;
    logic signed [I_W-1:0] diff;
    logic signed [I_W-1:0] prod_a;
    logic signed [I_W-1:0] new_v;
    logic signed [Q_W-1:0] upd_wd;

    logic                  tab_we;
    logic [T_W-1:0]        tab_wa;
    logic signed [Q_W-1:0] tab_wd;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    assign clr_last  = (clr_idx == T_W'(N_ENT - 1));
    assign scan_last = (scan_idx == A_W'(N_ACTIONS - 1));
    assign scanning  = (state == ST_SCAN_SEL) || (state == ST_SCAN_UPD);

    assign busy         = (state == ST_CLEAR);
    assign step_ready   = (state == ST_WAIT);
    assign action_valid = (state == ST_WAIT);
    assign accept       = step_valid && step_ready;

    // ---- scan: one table read per cycle, running max/argmax ----
    assign scan_tgt = (state == ST_SCAN_UPD) ? nxt_l : cur_state;
    assign scan_q   = q_tab[tab_addr(scan_tgt, scan_idx)];

    // Strictly-greater replacement keeps ties on the lowest action index.
    always_comb begin
        cand_q = best_q;
        cand_a = best_a;
        if ((scan_idx == '0) || (scan_q > best_q)) begin
            cand_q = scan_q;
            cand_a = scan_idx;
        end
    end

    // Epsilon-greedy choice, evaluated on the last SCAN_SEL cycle.
    assign explore_hit = explore_en && (lfsr[7:0] < epsilon);
    assign rnd_a       = lfsr[8 +: A_W];
    assign rnd_ok      = ({1'b0, rnd_a} < (A_W+1)'(N_ACTIONS));

    always_comb begin
        sel_action  = cand_a;
        sel_explore = 1'b0;
        if (explore_hit && rnd_ok) begin
            sel_action  = rnd_a;
            sel_explore = 1'b1;
        end
    end

    // ---- update: read-modify-write of Q[cur_state][action] ----
    assign upd_addr = tab_addr(cur_state, action);
    assign upd_q    = q_tab[upd_addr];

    assign gamma_s = $signed({{(I_W-4){1'b0}}, gamma});
    assign alpha_s = $signed({{(I_W-4){1'b0}}, alpha});
    assign maxq_s  = {{(I_W-Q_W){maxq_l[Q_W-1]}}, maxq_l};
    assign rew_s   = {{(I_W-R_W){rew_l[R_W-1]}}, rew_l};
    assign q_s     = {{(I_W-Q_W){upd_q[Q_W-1]}}, upd_q};

    assign prod_g = gamma_s * maxq_s;
    assign tgt    = rew_s + (prod_g >>> 4);
    assign diff   = tgt - q_s;
    assign prod_a = alpha_s * diff;
    assign new_v  = q_s + (prod_a >>> 4);
    assign upd_wd = sat_q(new_v);

    // Single table write port shared by clear and update.
    assign tab_we = (state == ST_CLEAR) || (state == ST_UPDATE);
    assign tab_wa = (state == ST_CLEAR) ? clr_idx : upd_addr;
    assign tab_wd = (state == ST_CLEAR) ? '0 : upd_wd;

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR:    if (clr_last)  state_nx = ST_IDLE;
            ST_IDLE:     if (start)     state_nx = ST_SCAN_SEL;
            ST_SCAN_SEL: if (scan_last) state_nx = ST_WAIT;
            ST_WAIT:     if (accept)    state_nx = terminal ? ST_UPDATE : ST_SCAN_UPD;
            ST_SCAN_UPD: if (scan_last) state_nx = ST_UPDATE;
            ST_UPDATE:   state_nx = term_l ? ST_IDLE : ST_SCAN_SEL;
            default:     state_nx = ST_CLEAR;
        endcase
    end

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            clr_idx      <= '0;
            scan_idx     <= '0;
            action       <= '0;
            cur_state    <= '0;
            explored     <= 1'b0;
            episode_done <= 1'b0;
            update_count <= '0;
        end else begin
            lfsr         <= lfsr_nx;
            episode_done <= 1'b0;

            if ((state == ST_CLEAR) && !clr_last) clr_idx <= clr_idx + T_W'(1);
            else                                  clr_idx <= '0;

            if (scanning && !scan_last) scan_idx <= scan_idx + A_W'(1);
            else                        scan_idx <= '0;

            case (state)
                ST_IDLE: begin
                    if (start) cur_state <= init_state;
                end
                ST_SCAN_SEL: begin
                    if (scan_last) begin
                        action   <= sel_action;
                        explored <= sel_explore;
                    end
                end
                ST_UPDATE: begin
                    update_count <= update_count + 32'd1;
                    if (term_l) episode_done <= 1'b1;
                    else        cur_state    <= nxt_l;
                end
                default: ;
            endcase
        end
    end

    // ---- data registers (no reset needed: always written before use) ----
    always_ff @(posedge clk) begin
        if (scanning) begin
            best_q <= cand_q;
            best_a <= cand_a;
        end
        if (accept) begin
            rew_l  <= $signed(reward);
            nxt_l  <= next_state;
            term_l <= terminal;
            if (terminal) maxq_l <= '0;
        end
        if ((state == ST_SCAN_UPD) && scan_last) maxq_l <= cand_q;
    end

    always_ff @(posedge clk) begin
        if (tab_we) q_tab[tab_wa] <= tab_wd;
    end

endmodule

// File: tb/tb_q_learning_agent_param.sv
// -----------------------------------------------------------------------------
// tb_q_learning_agent_param
//
// Directed and randomized bench for q_learning_agent_param (default
// parameters). A reference model holds the Q-table as plain integers, applies
// the update rule with integer arithmetic and predicts greedy/explored action
// choices from an LFSR sequence model.
// -----------------------------------------------------------------------------
module tb_q_learning_agent_param;

    localparam int NS = 64;
    localparam int NA = 4;
    localparam int NE = NS * NA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  init_state = '0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic [15:0] reward = '0;
    logic [5:0]  next_state = '0;
    logic        terminal = 1'b0;
    logic [3:0]  gamma = '0;
    logic [3:0]  alpha = '0;
    logic [7:0]  epsilon = '0;
    logic        explore_en = 1'b0;
    logic        action_valid;
    logic [1:0]  action;
    logic [5:0]  cur_state;
    logic        explored;
    logic        episode_done;
    logic        busy;
    logic [31:0] update_count;

    q_learning_agent_param dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .init_state   (init_state),
        .step_valid   (step_valid),
        .step_ready   (step_ready),
        .reward       (reward),
        .next_state   (next_state),
        .terminal     (terminal),
        .gamma        (gamma),
        .alpha        (alpha),
        .epsilon      (epsilon),
        .explore_en   (explore_en),
        .action_valid (action_valid),
        .action       (action),
        .cur_state    (cur_state),
        .explored     (explored),
        .episode_done (episode_done),
        .busy         (busy),
        .update_count (update_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          qm [NE];
    int          m_cur = 0;
    int          m_act = 0;
    int          m_cnt = 0;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;

    // Pseudo-random sequence: seed on reset, one step per clock otherwise.
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= rst ? 16'hACE1 : ((lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000));
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int q_update(input int q, input int r, input int mq,
                                    input int g, input int a);
        int t;
        t = r + ((g * mq) >>> 4);
        return sat16(q + ((a * (t - q)) >>> 4));
    endfunction

    function automatic void best_of(input int s, output int bq, output int ba);
        bq = qm[s*NA];
        ba = 0;
        for (int a = 1; a < NA; a++) begin
            if (qm[s*NA + a] > bq) begin
                bq = qm[s*NA + a];
                ba = a;
            end
        end
    endfunction

    function automatic void expect_choice(input int s, output int ea, output int ex);
        int bq, ba;
        best_of(s, bq, ba);
        if (explore_en && (lfsr_prev[7:0] < epsilon)) begin
            ea = int'(lfsr_prev[9:8]);
            ex = 1;
        end else begin
            ea = ba;
            ex = 0;
        end
    endfunction

    // Waits (bounded) for action_valid or episode_done, dropping one-shot inputs.
    task automatic wait_for(input bit want_done, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start      = 1'b0;
            step_valid = 1'b0;
        end while (!(want_done ? (episode_done === 1'b1) : (action_valid === 1'b1)) && lat < 300);
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_action_valid", action_valid, 0);
        chk("rst_step_ready",   step_ready,   0);
        chk("rst_explored",     explored,     0);
        chk("rst_episode_done", episode_done, 0);
        chk("rst_update_count", update_count, 0);
        chk("rst_action",       action,       0);
        chk("rst_cur_state",    cur_state,    0);
        chk("rst_busy",         busy,         1);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, NE);
        for (int i = 0; i < NE; i++) qm[i] = 0;
        m_cnt = 0;
    endtask

    task automatic do_start(input int s);
        int lat, ex;
        start      = 1'b1;
        init_state = 6'(s);
        wait_for(1'b0, lat);
        m_cur = s;
        expect_choice(s, m_act, ex);
        chk("start_latency",   lat,       NA + 1);
        chk("start_cur_state", cur_state, m_cur);
        chk("start_action",    action,    m_act);
        chk("start_explored",  explored,  ex);
    endtask

    task automatic do_step(input int r, input int ns, input bit term);
        int lat, idx, mq, ba, ex;
        step_valid = 1'b1;
        reward     = 16'(r);
        next_state = 6'(ns);
        terminal   = term;
        idx = m_cur * NA + m_act;
        if (term) mq = 0;
        else      best_of(ns, mq, ba);
        qm[idx] = q_update(qm[idx], r, mq, int'(gamma), int'(alpha));
        m_cnt++;
        wait_for(term, lat);
        chk(term ? "term_latency" : "step_latency", lat, term ? 2 : 2*NA + 2);
        chk("q_written",    dut.q_tab[idx], qm[idx]);
        chk("update_count", update_count,   m_cnt);
        if (term) begin
            chk("term_step_ready",   step_ready,   0);
            chk("term_action_valid", action_valid, 0);
        end else begin
            m_cur = ns;
            expect_choice(ns, m_act, ex);
            chk("step_cur_state", cur_state, m_cur);
            chk("step_action",    action,    m_act);
            chk("step_explored",  explored,  ex);
        end
    endtask

    initial begin
        int lat;

        // Reset, clear length, first action from an all-zero table.
        do_reset();
        explore_en = 1'b0;
        epsilon    = 8'd0;
        alpha      = 4'd8;
        gamma      = 4'd8;
        do_start(5);
        chk("first_action",   action,    0);
        chk("first_explored", explored,  0);
        chk("first_state",    cur_state, 5);

        // Non-terminal step: Q[5][0] = 0 + 8*160/16 = 80.
        do_step(160, 6, 1'b0);
        chk("q50_80",     dut.q_tab[5*NA + 0], 80);
        chk("cnt_one",    update_count, 1);
        chk("next_state", cur_state, 6);

        // Terminal step from a fresh table: Q[5][0] = 15*(-16)/16 = -15.
        do_reset();
        alpha = 4'd15;
        do_start(5);
        do_step(-16, 0, 1'b1);
        chk("q50_neg15", dut.q_tab[5*NA + 0], -15);
        @(negedge clk);
        chk("done_pulse_end", episode_done, 0);
        chk("idle_ready",     step_ready,   0);

        // Restart at 5 with a step_valid pulse during the selection scan.
        start      = 1'b1;
        init_state = 6'd5;
        @(negedge clk);
        start      = 1'b0;
        step_valid = 1'b1;
        reward     = 16'd100;
        terminal   = 1'b0;
        wait_for(1'b0, lat);
        lat = lat + 1;
        chk("scan_pulse_latency", lat, NA + 1);
        chk("scan_pulse_count",   update_count, 1);
        chk("tie_low_index",      action, 1);
        m_cur = 5;
        m_act = 1;

        // Reset while waiting for a step result.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_action_valid", action_valid, 0);
        chk("rst_wait_busy",         busy,         1);
        do_reset();
        chk("q50_cleared", dut.q_tab[5*NA + 0], 0);
        do_start(5);
        chk("cleared_action", action, 0);

        // Self-loop on state 3 with maximal reward: climbs and clamps.
        do_reset();
        alpha = 4'd15;
        gamma = 4'd15;
        do_start(3);
        for (int i = 0; i < 30; i++) begin
            do_step(32767, 3, 1'b0);
            chk("selfloop_nonneg", (dut.q_tab[3*NA + 0] >= 0) ? 1 : 0, 1);
        end
        chk("selfloop_clamp", dut.q_tab[3*NA + 0], 32767);

        // Randomized steps with full exploration, then with none.
        explore_en = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            epsilon = (phase == 0) ? 8'd255 : 8'd0;
            for (int i = 0; i < 100; i++) begin
                alpha = 4'($urandom_range(0, 15));
                gamma = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) begin
                    do_step(int'($urandom_range(0, 4000)) - 2000, 0, 1'b1);
                    do_start(int'($urandom_range(0, NS - 1)));
                end else begin
                    do_step(int'($urandom_range(0, 4000)) - 2000,
                            int'($urandom_range(0, NS - 1)), 1'b0);
                end
                if (phase == 1) chk("eps0_not_explored", explored, 0);
            end
        end

        // Whole-table comparison against the model.
        for (int i = 0; i < NE; i++) chk("table_entry", dut.q_tab[i], qm[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
